// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin owner of one shared burst memory port.
// Define MEM_ARB_FIXED_PRIO_EN to make B (D-cache) win every tie.
module mem_port_arbiter #(
   parameter int BURST_LEN = 4,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              a_req_i,
   input  logic              a_we_i,
   input  logic [ADDR_W-1:0] a_addr_i,
   input  logic [DATA_W-1:0] a_wdata_i,
   output logic              a_gnt_o,
   output logic              a_rvalid_o,
   output logic              a_done_o,
   input  logic              b_req_i,
   input  logic              b_we_i,
   input  logic [ADDR_W-1:0] b_addr_i,
   input  logic [DATA_W-1:0] b_wdata_i,
   output logic              b_gnt_o,
   output logic              b_rvalid_o,
   output logic              b_done_o,
   output logic [DATA_W-1:0] rdata_o,
   output logic              se_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic              mem_gnt_i,
   input  logic              mem_rvalid_i,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              busy_o
);
   localparam int CW = $clog2(BURST_LEN) + 1;
   localparam int OW = $clog2(BURST_LEN) + 2;
   localparam logic [CW-1:0] LAST = CW'(BURST_LEN - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_RSP
   } state_t;

   state_t            r_state;
   state_t            w_state_n;
   logic              r_se;
   logic              r_we;
   logic [ADDR_W-1:0] r_base;
   logic [CW-1:0]     r_beat;
   logic [CW-1:0]     r_rsp;
   logic              w_pick_b;
   logic              w_grant;
   logic              w_acc;
   logic              w_rsp;
   logic              w_done;
   logic              w_issue;
   logic [OW-1:0]     w_off;

`ifdef MEM_ARB_FIXED_PRIO_EN
   assign w_pick_b = b_req_i;
`else
   logic r_last;

   assign w_pick_b = b_req_i & (~a_req_i | ~r_last);

   // remember who owned the finished burst (1 = B) for the next tie
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_last <= 1'b1;
      end else if (w_done) begin
         r_last <= r_se;
      end
   end
`endif

   // next-state and per-cycle strobes
   always_comb begin
      w_state_n = r_state;
      w_grant   = 1'b0;
      w_acc     = 1'b0;
      w_rsp     = 1'b0;
      w_done    = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (a_req_i | b_req_i) begin
               w_grant   = 1'b1;
               w_state_n = S_ISSUE;
            end
         end
         S_ISSUE: begin
            w_acc = mem_gnt_i;
            w_rsp = mem_rvalid_i & ~r_we;
            if (w_rsp && r_rsp == LAST) begin
               w_done    = 1'b1;
               w_state_n = S_IDLE;
            end else if (w_acc && r_beat == LAST) begin
               if (r_we) begin
                  w_done    = 1'b1;
                  w_state_n = S_IDLE;
               end else begin
                  w_state_n = S_WAIT_RSP;
               end
            end
         end
         S_WAIT_RSP: begin
            w_rsp = mem_rvalid_i;
            if (w_rsp && r_rsp == LAST) begin
               w_done    = 1'b1;
               w_state_n = S_IDLE;
            end
         end
         default: w_state_n = S_IDLE;
      endcase
   end

   // state, owner latch and beat/response counters
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= S_IDLE;
         r_se    <= 1'b0;
         r_we    <= 1'b0;
         r_base  <= '0;
         r_beat  <= '0;
         r_rsp   <= '0;
      end else begin
         r_state <= w_state_n;
         if (w_grant) begin
            r_se   <= w_pick_b;
            r_we   <= w_pick_b ? b_we_i : a_we_i;
            r_base <= w_pick_b ? b_addr_i : a_addr_i;
            r_beat <= '0;
            r_rsp  <= '0;
         end else begin
            if (w_acc) r_beat <= r_beat + 1'b1;
            if (w_rsp) r_rsp <= r_rsp + 1'b1;
         end
      end
   end

   // offset wraps inside the burst block; upper bits stay from base
   assign w_off = r_base[OW-1:0] + OW'({r_beat, 2'b00});

   assign w_issue     = (r_state == S_ISSUE);
   assign mem_req_o   = w_issue;
   assign mem_we_o    = w_issue & r_we;
   assign mem_addr_o  = w_issue ? {r_base[ADDR_W-1:OW], w_off} : '0;
   assign mem_wdata_o = w_issue ? (r_se ? b_wdata_i : a_wdata_i) : '0;

   assign a_gnt_o    = w_acc & ~r_se;
   assign b_gnt_o    = w_acc & r_se;
   assign a_rvalid_o = w_rsp & ~r_se;
   assign b_rvalid_o = w_rsp & r_se;
   assign a_done_o   = w_done & ~r_se;
   assign b_done_o   = w_done & r_se;
   assign rdata_o    = w_rsp ? mem_rdata_i : '0;
   assign se_o       = r_se;
   assign busy_o     = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bursts checked against a burst-level
// model every cycle, plus hand-computed address/order/timing literals.
module tb_mem_port_arbiter;
   localparam int BL  = 4;
   localparam int BLK = BL * 4;

   logic        clk = 1'b0;
   logic        rst_ni = 1'b0;
   logic        a_req_i = 1'b0, a_we_i = 1'b0;
   logic [31:0] a_addr_i = '0, a_wdata_i = '0;
   logic        b_req_i = 1'b0, b_we_i = 1'b0;
   logic [31:0] b_addr_i = '0, b_wdata_i = '0;
   logic        mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
   logic [31:0] mem_rdata_i = '0;
   logic        a_gnt_o, a_rvalid_o, a_done_o;
   logic        b_gnt_o, b_rvalid_o, b_done_o;
   logic [31:0] rdata_o, mem_addr_o, mem_wdata_o;
   logic        se_o, mem_req_o, mem_we_o, busy_o;

   always #5 clk = ~clk;

   mem_port_arbiter #(.BURST_LEN(BL), .ADDR_W(32), .DATA_W(32)) dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .a_req_i(a_req_i), .a_we_i(a_we_i), .a_addr_i(a_addr_i),
      .a_wdata_i(a_wdata_i), .a_gnt_o(a_gnt_o), .a_rvalid_o(a_rvalid_o),
      .a_done_o(a_done_o),
      .b_req_i(b_req_i), .b_we_i(b_we_i), .b_addr_i(b_addr_i),
      .b_wdata_i(b_wdata_i), .b_gnt_o(b_gnt_o), .b_rvalid_o(b_rvalid_o),
      .b_done_o(b_done_o),
      .rdata_o(rdata_o), .se_o(se_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
      .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
      .busy_o(busy_o)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // burst-level reference model
   bit          m_busy = 0, m_own = 0, m_we = 0, m_last = 1;
   logic [31:0] m_base = '0;
   int          m_iss = 0, m_rsp = 0;

   // environment state
   bit          s_acc_rd = 0, s_a_gnt = 0, s_b_gnt = 0;
   bit          s_a_done = 0, s_b_done = 0;
   bit          a_keep = 0, b_keep = 0, stall = 0, prev_busy = 0;
   int          acnt = 0, bcnt = 0;
   logic [31:0] rd_next = 32'h1000;

   // event logs (from DUT outputs, compared to literals)
   int          done_own[$], done_cyc[$], start_own[$], start_cyc[$];
   logic [31:0] acc_addr[$], acc_wd[$];
   int          a_rv_n = 0, b_rv_n = 0, a_gnt_n = 0, b_gnt_n = 0;

   task automatic chk(string name, logic [127:0] got, logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   function automatic logic [105:0] outs();
      return {a_gnt_o, a_rvalid_o, a_done_o, b_gnt_o, b_rvalid_o, b_done_o,
              se_o, mem_req_o, mem_we_o, busy_o,
              mem_addr_o, mem_wdata_o, rdata_o};
   endfunction

   task automatic model_check();
      logic [105:0] exp;
      logic [31:0]  e_addr, e_wd, e_rd;
      bit           iss, acc, rsp, done;
      exp = '0;
      if (!rst_ni) begin
         m_busy = 0; m_own = 0; m_last = 1;
      end else if (!m_busy) begin
         exp[99] = m_own;
         if (a_req_i || b_req_i) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            m_own = b_req_i;
`else
            m_own = b_req_i && (!a_req_i || !m_last);
`endif
            m_we   = m_own ? b_we_i : a_we_i;
            m_base = m_own ? b_addr_i : a_addr_i;
            m_iss  = 0;
            m_rsp  = 0;
            m_busy = 1;
         end
      end else begin
         iss  = m_iss < BL;
         acc  = iss && mem_gnt_i;
         rsp  = !m_we && mem_rvalid_i;
         done = (m_we && acc && m_iss == BL - 1) || (rsp && m_rsp == BL - 1);
         e_addr = iss ? ((m_base & ~32'(BLK - 1)) |
                         ((m_base + 32'(4 * m_iss)) & 32'(BLK - 1))) : '0;
         e_wd = iss ? (m_own ? b_wdata_i : a_wdata_i) : '0;
         e_rd = rsp ? mem_rdata_i : '0;
         exp = {acc && !m_own, rsp && !m_own, done && !m_own,
                acc && m_own, rsp && m_own, done && m_own,
                m_own, iss, iss && m_we, 1'b1, e_addr, e_wd, e_rd};
         m_iss += int'(acc);
         m_rsp += int'(rsp);
         if (done) begin
            m_busy = 0;
            m_last = m_own;
         end
      end
      chk("cycle outputs", outs(), exp);
      if (mem_req_o && mem_gnt_i) begin
         acc_addr.push_back(mem_addr_o);
         acc_wd.push_back(mem_wdata_o);
      end
      if (busy_o && !prev_busy) begin
         start_cyc.push_back(cyc);
         start_own.push_back(int'(se_o));
      end
      prev_busy = busy_o;
      if (a_done_o) begin done_own.push_back(0); done_cyc.push_back(cyc); end
      if (b_done_o) begin done_own.push_back(1); done_cyc.push_back(cyc); end
      a_rv_n  += int'(a_rvalid_o);
      b_rv_n  += int'(b_rvalid_o);
      a_gnt_n += int'(a_gnt_o);
      b_gnt_n += int'(b_gnt_o);
      s_acc_rd = rst_ni && mem_req_o && mem_gnt_i && !mem_we_o;
      s_a_gnt  = rst_ni && a_gnt_o;
      s_b_gnt  = rst_ni && b_gnt_o;
      s_a_done = rst_ni && a_done_o;
      s_b_done = rst_ni && b_done_o;
   endtask

   task automatic drive_next();
      mem_rvalid_i = s_acc_rd;
      mem_rdata_i  = s_acc_rd ? rd_next : '0;
      if (s_acc_rd) rd_next++;
      if (!rst_ni) begin
         acnt = 0;
         bcnt = 0;
      end
      if (s_a_done) begin
         acnt = 0;
         if (!a_keep) a_req_i = 1'b0;
      end else if (s_a_gnt) acnt++;
      if (s_b_done) begin
         bcnt = 0;
         if (!b_keep) b_req_i = 1'b0;
      end else if (s_b_gnt) bcnt++;
      a_wdata_i = 32'h50 + 32'(acnt);
      b_wdata_i = 32'hA0 + 32'(bcnt);
      mem_gnt_i = stall ? ~mem_gnt_i : 1'b1;
   endtask

   task automatic step();
      @(negedge clk);
      cyc++;
      model_check();
      @(posedge clk);
      #1;
      drive_next();
   endtask

   task automatic wait_done(int target, int lim);
      int k = 0;
      while (done_own.size() < target && k < lim) begin
         step();
         k++;
      end
      chk("burst timeout", 128'(done_own.size() >= target), 128'(1));
   endtask

   initial begin
      int n0, s0, a0, rv0, brv0, bg0, g0, t_req, k;
      logic [31:0] addr_exp [4];
      int          ord_exp [4];

      // reset
      step();
      step();
      chk("reset outputs", 128'(outs()), '0);
      rst_ni = 1'b1;
      step();

      // T1: single A read at 0x100
      n0 = done_own.size(); s0 = start_cyc.size(); a0 = acc_addr.size();
      rv0 = a_rv_n; brv0 = b_rv_n; bg0 = b_gnt_n;
      a_we_i = 1'b0; a_addr_i = 32'h100; a_req_i = 1'b1;
      t_req = cyc + 1;
      wait_done(n0 + 1, 40);
      addr_exp = '{32'h100, 32'h104, 32'h108, 32'h10C};
      for (int i = 0; i < 4; i++) chk("t1 addr", acc_addr[a0 + i], addr_exp[i]);
      chk("t1 latency", start_cyc[s0], t_req + 1);
      chk("t1 se", start_own[s0], 0);
      chk("t1 rvalid count", a_rv_n - rv0, 4);
      chk("t1 done owner", done_own[n0], 0);
      chk("t1 done cycle", done_cyc[n0] - start_cyc[s0], 4);
      chk("t1 b quiet", (b_rv_n - brv0) + (b_gnt_n - bg0), 0);
      step(); step();

      // T2: B write at 0x2008, memory stalls every other cycle
      n0 = done_own.size(); s0 = start_cyc.size(); a0 = acc_addr.size();
      bg0 = b_gnt_n;
      stall = 1;
      b_we_i = 1'b1; b_addr_i = 32'h2008; b_req_i = 1'b1;
      wait_done(n0 + 1, 60);
      addr_exp = '{32'h2008, 32'h200C, 32'h2000, 32'h2004};
      for (int i = 0; i < 4; i++) begin
         chk("t2 addr", acc_addr[a0 + i], addr_exp[i]);
         chk("t2 wdata", acc_wd[a0 + i], 32'hA0 + 32'(i));
      end
      chk("t2 se", start_own[s0], 1);
      chk("t2 gnt count", b_gnt_n - bg0, 4);
      chk("t2 done owner", done_own[n0], 1);
      stall = 0;
      step(); step();

      // T3: both requesting continuously from reset
      rst_ni = 1'b0;
      step();
      rst_ni = 1'b1;
      n0 = done_own.size();
      a_keep = 1; b_keep = 1;
      a_we_i = 1'b0; a_addr_i = 32'h300;
      b_we_i = 1'b1; b_addr_i = 32'h400;
      a_req_i = 1'b1; b_req_i = 1'b1;
      wait_done(n0 + 4, 200);
      a_keep = 0; b_keep = 0;
      a_req_i = 1'b0; b_req_i = 1'b0;
`ifdef MEM_ARB_FIXED_PRIO_EN
      ord_exp = '{1, 1, 1, 1};
`else
      ord_exp = '{0, 1, 0, 1};
`endif
      for (int i = 0; i < 4; i++) chk("t3 grant order", done_own[n0 + i], ord_exp[i]);
      step(); step(); step();

      // T4: B requests while A burst is running
      n0 = done_own.size(); s0 = start_cyc.size();
      rv0 = a_rv_n; brv0 = b_rv_n;
      a_we_i = 1'b0; a_addr_i = 32'h500; a_req_i = 1'b1;
      step(); step();
      b_we_i = 1'b0; b_addr_i = 32'h600; b_req_i = 1'b1;
      wait_done(n0 + 2, 80);
      chk("t4 first owner", done_own[n0], 0);
      chk("t4 second owner", done_own[n0 + 1], 1);
      chk("t4 se first", start_own[s0], 0);
      chk("t4 se second", start_own[s0 + 1], 1);
      chk("t4 idle gap", start_cyc[s0 + 1] - done_cyc[n0], 2);
      chk("t4 a rvalids", a_rv_n - rv0, 4);
      chk("t4 b rvalids", b_rv_n - brv0, 4);
      step(); step();

      // T5: reset after two accepted beats of a read
      g0 = a_gnt_n;
      a_we_i = 1'b0; a_addr_i = 32'h700; a_req_i = 1'b1;
      k = 0;
      while (a_gnt_n - g0 < 2 && k < 20) begin
         step();
         k++;
      end
      chk("t5 two beats", 128'(a_gnt_n - g0 >= 2), 128'(1));
      rst_ni = 1'b0;
      a_req_i = 1'b0;
      #1;
      chk("t5 reset outputs", 128'(outs()), '0);
      step();
      rst_ni = 1'b1;
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'h55;
      #1;
      chk("t5 late rvalid", {a_rvalid_o, b_rvalid_o}, 2'b00);
      step(); step();

      // T6: stray rvalid while idle, then a normal read
      n0 = done_own.size(); s0 = start_cyc.size(); rv0 = a_rv_n;
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'hDEADBEEF;
      #1;
      chk("t6 idle rvalid", {a_rvalid_o, b_rvalid_o}, 2'b00);
      step();
      a_we_i = 1'b0; a_addr_i = 32'h800; a_req_i = 1'b1;
      wait_done(n0 + 1, 40);
      chk("t6 rvalid count", a_rv_n - rv0, 4);
      chk("t6 done cycle", done_cyc[n0] - start_cyc[s0], 4);
      step(); step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
